// File: rtl/multicycle_control.sv
// multicycle_control
//   Control FSM for the multi-cycle RV32I datapath. Steps each instruction
//   through FETCH / DECODE / EXEC / MEM / WB and drives the per-step datapath
//   controls. It stalls on the instruction and data memory ready handshakes
//   and counts retired instructions.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   0     | FETCH  : imem request; IR/PC load in the imem_ready cycle
//   1     | DECODE : latch opcode class; flag unsupported opcodes
//   2     | EXEC   : ALU operation for the latched class
//   3     | MEM    : data memory access, held until dmem_ready
//   4     | WB     : register-file write
//   5..7  | unreachable; recover to FETCH
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   opcode               IR opcode field, sampled in DECODE only
//   imem_ready           instruction data valid (honoured in FETCH only)
//   dmem_ready           data access completes (honoured in MEM only)
//   state                current step, 0 while rst is high
//   imem_req, ir_write, pc_write                 fetch controls
//   dmem_req, MemRead, MemWrite                  data memory controls
//   RegWrite, MemtoReg, ALUSrc, ALUOp, Branch    datapath controls
//   illegal              one-cycle pulse in DECODE for unsupported opcodes
//   instret              retired-instruction count, wraps
module multicycle_control #(
  parameter int OPCODE_WIDTH = 7,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    imem_ready,
  input  logic                    dmem_ready,
  output logic [2:0]              state,
  output logic                    imem_req,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    dmem_req,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    RegWrite,
  output logic                    MemtoReg,
  output logic                    ALUSrc,
  output logic [1:0]              ALUOp,
  output logic                    Branch,
  output logic                    illegal,
  output logic [CNT_W-1:0]        instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_R    = 3'd1;
  localparam logic [2:0] C_ADDI = 3'd2;
  localparam logic [2:0] C_LW   = 3'd3;
  localparam logic [2:0] C_S    = 3'd4;
  localparam logic [2:0] C_B    = 3'd5;
  localparam logic [2:0] C_J    = 3'd6;

  localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_S    = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_B    = OPCODE_WIDTH'(7'b1100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_J    = OPCODE_WIDTH'(7'b1101111);

  logic [2:0]       state_q, state_d;
  logic [2:0]       cls_q, cls_dec;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  always_comb begin
    cls_dec = C_NONE;
    case (opcode)
      OP_R:    cls_dec = C_R;
      OP_ADDI: cls_dec = C_ADDI;
      OP_LW:   cls_dec = C_LW;
      OP_S:    cls_dec = C_S;
      OP_B:    cls_dec = C_B;
      OP_J:    cls_dec = C_J;
      default: cls_dec = C_NONE;
    endcase
  end

  // An instruction retires on the edge leaving its final step.
  assign retire = (state_q == S_WB)
               || (state_q == S_EXEC && cls_q == C_B)
               || (state_q == S_MEM && cls_q == C_S && dmem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_dec;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = (cls_dec == C_NONE) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_LW, C_S:       state_d = S_MEM;
          C_B:             state_d = S_FETCH;
          C_R, C_ADDI, C_J: state_d = S_WB;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!dmem_ready)        state_d = S_MEM;
        else if (cls_q == C_LW) state_d = S_WB;
        else                    state_d = S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Everything is forced low while rst is high so no request or write
  // enable escapes during the reset cycle, whatever state was in flight.
  always_comb begin
    state    = 3'd0;
    imem_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    dmem_req = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    Branch   = 1'b0;
    illegal  = 1'b0;
    instret  = '0;
    if (!rst) begin
      state   = state_q;
      instret = cnt_q;
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
        // Class is not latched until the end of DECODE, so the illegal
        // flag comes straight from the live opcode.
        S_DECODE: illegal = (cls_dec == C_NONE);
        S_EXEC: begin
          case (cls_q)
            C_R:             ALUOp  = 2'b10;
            C_ADDI, C_LW, C_S: ALUSrc = 1'b1;
            C_B: begin
              ALUOp  = 2'b01;
              Branch = 1'b1;
            end
            C_J:             Branch = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          MemRead  = (cls_q == C_LW);
          MemWrite = (cls_q == C_S);
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = (cls_q == C_LW);
        end
        default: ;
      endcase
    end
  end

endmodule
